// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator: classifies each instruction, sign-extends
// its immediate to XLEN and delivers it with a passthrough tag over valid/ready.
module imm_gen_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 1,
  parameter int TAG_W  = 32,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  // The word-sized opcodes (OP-IMM-32 / OP-32) only exist on RV64.
  function automatic logic [2:0] decode_fmt(input logic [31:0] instr);
    logic [2:0] f;
    f = FMT_ILL;
    case (instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111,
      7'b0001111, 7'b1110011: f = FMT_I;
      7'b0100011:             f = FMT_S;
      7'b1100011:             f = FMT_B;
      7'b0110111, 7'b0010111: f = FMT_U;
      7'b1101111:             f = FMT_J;
      7'b0110011:             f = FMT_R;
      7'b0011011:             f = (XLEN == 64) ? FMT_I : FMT_ILL;
      7'b0111011:             f = (XLEN == 64) ? FMT_R : FMT_ILL;
      default:                f = FMT_ILL;
    endcase
    return f;
  endfunction

  // Build the 32-bit immediate, then sign-extend from bit 31 to XLEN.
  function automatic logic [XLEN-1:0] build_imm(input logic [31:0] instr, input logic [2:0] fmt);
    logic [31:0] v;
    v = '0;
    case (fmt)
      FMT_I: v = {{20{instr[31]}}, instr[31:20]};
      FMT_S: v = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: v = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U: v = {instr[31:12], 12'b0};
      FMT_J: v = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: v = '0;
    endcase
    return XLEN'(signed'(v));
  endfunction

  logic out_load;
  assign out_load = !out_valid || out_ready;

  if (STAGES == 1) begin : g_one
    logic [2:0] in_fmt;
    assign in_fmt   = decode_fmt(in_instr);
    assign in_ready = !reset && !flush && out_load;

    always_ff @(posedge clk) begin
      if (reset) begin
        out_valid   <= 1'b0;
        out_imm     <= '0;
        out_fmt     <= FMT_R;
        out_illegal <= 1'b0;
        out_tag     <= '0;
      end else if (flush) begin
        out_valid <= 1'b0;
      end else if (out_load) begin
        out_valid <= in_valid;
        if (in_valid) begin
          out_imm     <= build_imm(in_instr, in_fmt);
          out_fmt     <= in_fmt;
          out_illegal <= (in_fmt == FMT_ILL);
          out_tag     <= in_tag;
        end
      end
    end
  end else begin : g_two
    logic             s1_valid;
    logic [31:0]      s1_instr;
    logic [2:0]       s1_fmt;
    logic [TAG_W-1:0] s1_tag;
    logic             s1_advance;

    assign s1_advance = !s1_valid || out_load;
    assign in_ready   = !reset && !flush && s1_advance;

    // Stage 1 decodes and keeps the raw word; stage 2 builds the immediate.
    always_ff @(posedge clk) begin
      if (reset) begin
        s1_valid    <= 1'b0;
        s1_instr    <= '0;
        s1_fmt      <= FMT_R;
        s1_tag      <= '0;
        out_valid   <= 1'b0;
        out_imm     <= '0;
        out_fmt     <= FMT_R;
        out_illegal <= 1'b0;
        out_tag     <= '0;
      end else if (flush) begin
        s1_valid  <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        if (out_load) begin
          out_valid <= s1_valid;
          if (s1_valid) begin
            out_imm     <= build_imm(s1_instr, s1_fmt);
            out_fmt     <= s1_fmt;
            out_illegal <= (s1_fmt == FMT_ILL);
            out_tag     <= s1_tag;
          end
        end
        if (s1_advance) begin
          s1_valid <= in_valid;
          if (in_valid) begin
            s1_instr <= in_instr;
            s1_fmt   <= decode_fmt(in_instr);
            s1_tag   <= in_tag;
          end
        end
      end
    end
  end

  // Only delivered illegal results count; flushed ones never reach the output transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_cnt <= '0;
    end else if (out_valid && out_ready && out_illegal && (illegal_cnt != {CNT_W{1'b1}})) begin
      illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: table of decode vectors on single-stage instances,
// plus hand-written backpressure, flush, reset and saturation sequences.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_tag;

  logic        in_ready_a, out_valid_a, out_illegal_a;
  logic [31:0] out_imm_a, out_tag_a;
  logic [2:0]  out_fmt_a;
  logic [15:0] cnt_a;

  logic        in_ready_b, out_valid_b, out_illegal_b;
  logic [63:0] out_imm_b;
  logic [31:0] out_tag_b;
  logic [2:0]  out_fmt_b;
  logic [15:0] cnt_b;

  logic        in_ready_c, out_valid_c, out_illegal_c;
  logic [31:0] out_imm_c, out_tag_c;
  logic [2:0]  out_fmt_c;
  logic [15:0] cnt_c;

  logic        in_ready_d, out_valid_d, out_illegal_d;
  logic [31:0] out_imm_d, out_tag_d;
  logic [2:0]  out_fmt_d;
  logic [1:0]  cnt_d;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .STAGES(1), .TAG_W(32), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_imm(out_imm_a), .out_fmt(out_fmt_a), .out_illegal(out_illegal_a),
    .out_tag(out_tag_a), .illegal_cnt(cnt_a));

  imm_gen_pipe #(.XLEN(64), .STAGES(1), .TAG_W(32), .CNT_W(16)) u_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_imm(out_imm_b), .out_fmt(out_fmt_b), .out_illegal(out_illegal_b),
    .out_tag(out_tag_b), .illegal_cnt(cnt_b));

  imm_gen_pipe #(.XLEN(32), .STAGES(2), .TAG_W(32), .CNT_W(16)) u_c (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_c),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid_c), .out_ready(out_ready),
    .out_imm(out_imm_c), .out_fmt(out_fmt_c), .out_illegal(out_illegal_c),
    .out_tag(out_tag_c), .illegal_cnt(cnt_c));

  imm_gen_pipe #(.XLEN(32), .STAGES(1), .TAG_W(32), .CNT_W(2)) u_d (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_d),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid_d), .out_ready(out_ready),
    .out_imm(out_imm_d), .out_fmt(out_fmt_d), .out_illegal(out_illegal_d),
    .out_tag(out_tag_d), .illegal_cnt(cnt_d));

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  fmt32;
    logic [31:0] imm32;
    logic [2:0]  fmt64;
    logic [63:0] imm64;
  } vec_t;

  localparam int N = 18;
  vec_t vecs[N];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act !== exp) $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else passCount++;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] tag);
    in_valid = v;
    in_instr = instr;
    in_tag   = tag;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int expA, expB;
    vecs[0]  = '{32'hFFF00093, 3'd1, 32'hFFFFFFFF, 3'd1, 64'hFFFFFFFFFFFFFFFF};
    vecs[1]  = '{32'hFE112E23, 3'd2, 32'hFFFFFFFC, 3'd2, 64'hFFFFFFFFFFFFFFFC};
    vecs[2]  = '{32'h12345037, 3'd4, 32'h12345000, 3'd4, 64'h0000000012345000};
    vecs[3]  = '{32'hFFDFF06F, 3'd5, 32'hFFFFFFFC, 3'd5, 64'hFFFFFFFFFFFFFFFC};
    vecs[4]  = '{32'h00000033, 3'd0, 32'h00000000, 3'd0, 64'h0};
    vecs[5]  = '{32'h80000037, 3'd4, 32'h80000000, 3'd4, 64'hFFFFFFFF80000000};
    vecs[6]  = '{32'hFFF0809B, 3'd7, 32'h00000000, 3'd1, 64'hFFFFFFFFFFFFFFFF};
    vecs[7]  = '{32'h0000003B, 3'd7, 32'h00000000, 3'd0, 64'h0};
    vecs[8]  = '{32'h00000000, 3'd7, 32'h00000000, 3'd7, 64'h0};
    vecs[9]  = '{32'hFE000EE3, 3'd3, 32'hFFFFFFFC, 3'd3, 64'hFFFFFFFFFFFFFFFC};
    vecs[10] = '{32'h00000463, 3'd3, 32'h00000008, 3'd3, 64'h8};
    vecs[11] = '{32'h0080006F, 3'd5, 32'h00000008, 3'd5, 64'h8};
    vecs[12] = '{32'h7FF00013, 3'd1, 32'h000007FF, 3'd1, 64'h7FF};
    vecs[13] = '{32'h00402083, 3'd1, 32'h00000004, 3'd1, 64'h4};
    vecs[14] = '{32'hFFC08067, 3'd1, 32'hFFFFFFFC, 3'd1, 64'hFFFFFFFFFFFFFFFC};
    vecs[15] = '{32'hFFFFF017, 3'd4, 32'hFFFFF000, 3'd4, 64'hFFFFFFFFFFFFF000};
    vecs[16] = '{32'h00000012, 3'd7, 32'h00000000, 3'd7, 64'h0};
    vecs[17] = '{32'h0000100F, 3'd1, 32'h00000000, 3'd1, 64'h0};

    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0);
    step();
    step();
    checkOutput("reset out_valid", 64'(out_valid_a), 64'd0);
    checkOutput("reset out_imm", 64'(out_imm_a), 64'd0);
    checkOutput("reset out_fmt", 64'(out_fmt_a), 64'd0);
    checkOutput("reset out_illegal", 64'(out_illegal_a), 64'd0);
    checkOutput("reset out_tag", 64'(out_tag_a), 64'd0);
    checkOutput("reset illegal_cnt", 64'(cnt_a), 64'd0);
    checkOutput("reset in_ready", 64'(in_ready_a), 64'd0);
    reset = 1'b0;
    #1;
    checkOutput("release in_ready", 64'(in_ready_a), 64'd1);

    // Back-to-back stream through the single-stage XLEN=32 and XLEN=64 instances.
    expA = 0; expB = 0;
    applyStimulus(1'b1, vecs[0].instr, 32'h1000);
    for (int i = 0; i < N; i++) begin
      step();
      checkOutput($sformatf("v%0d valid32", i), 64'(out_valid_a), 64'd1);
      checkOutput($sformatf("v%0d fmt32", i), 64'(out_fmt_a), 64'(vecs[i].fmt32));
      checkOutput($sformatf("v%0d imm32", i), 64'(out_imm_a), 64'(vecs[i].imm32));
      checkOutput($sformatf("v%0d illegal32", i), 64'(out_illegal_a), 64'(vecs[i].fmt32 == 3'd7));
      checkOutput($sformatf("v%0d tag32", i), 64'(out_tag_a), 64'(32'h1000 + 32'(i) * 4));
      checkOutput($sformatf("v%0d fmt64", i), 64'(out_fmt_b), 64'(vecs[i].fmt64));
      checkOutput($sformatf("v%0d imm64", i), out_imm_b, vecs[i].imm64);
      if (vecs[i].fmt32 == 3'd7) expA++;
      if (vecs[i].fmt64 == 3'd7) expB++;
      if (i + 1 < N) applyStimulus(1'b1, vecs[i+1].instr, 32'h1000 + 32'(i + 1) * 4);
      else applyStimulus(1'b0, 32'h0, 32'h0);
      #1;
      checkOutput($sformatf("v%0d in_ready", i), 64'(in_ready_a), 64'd1);
    end
    step();
    checkOutput("stream drained", 64'(out_valid_a), 64'd0);
    checkOutput("cnt32 after stream", 64'(cnt_a), 64'(expA));
    checkOutput("cnt64 after stream", 64'(cnt_b), 64'(expB));
    checkOutput("cnt saturated", 64'(cnt_d), 64'((expA > 3) ? 3 : expA));

    // Illegal delivery, then an illegal killed by flush must not count.
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    checkOutput("post-reset in_ready", 64'(in_ready_a), 64'd1);
    checkOutput("post-reset out_valid", 64'(out_valid_a), 64'd0);
    applyStimulus(1'b1, 32'h00000000, 32'h2000);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkOutput("ill out_illegal", 64'(out_illegal_a), 64'd1);
    checkOutput("ill out_fmt", 64'(out_fmt_a), 64'd7);
    checkOutput("ill cnt before", 64'(cnt_a), 64'd0);
    step();
    checkOutput("ill cnt after", 64'(cnt_a), 64'd1);
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'hFFFFFFFF, 32'h2008);
    step();
    checkOutput("held illegal valid", 64'(out_valid_a), 64'd1);
    applyStimulus(1'b1, 32'h00100093, 32'h200C);
    flush = 1'b1;
    #1;
    checkOutput("flush in_ready", 64'(in_ready_a), 64'd0);
    step();
    flush = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkOutput("flush out_valid", 64'(out_valid_a), 64'd0);
    out_ready = 1'b1;
    step();
    step();
    checkOutput("flush cnt kept", 64'(cnt_a), 64'd1);
    checkOutput("flush nothing out", 64'(out_valid_a), 64'd0);

    // Two-stage backpressure: two accepted, third stalls, then all drain in order.
    reset = 1'b1;
    step();
    reset = 1'b0;
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'h00100093, 32'h3000);
    #1;
    checkOutput("bp in_ready A", 64'(in_ready_c), 64'd1);
    step();
    checkOutput("bp latency", 64'(out_valid_c), 64'd0);
    applyStimulus(1'b1, 32'h00200093, 32'h3004);
    #1;
    checkOutput("bp in_ready B", 64'(in_ready_c), 64'd1);
    step();
    checkOutput("bp valid A", 64'(out_valid_c), 64'd1);
    checkOutput("bp tag A", 64'(out_tag_c), 64'h3000);
    applyStimulus(1'b1, 32'h00300093, 32'h3008);
    #1;
    checkOutput("bp in_ready C", 64'(in_ready_c), 64'd0);
    step();
    checkOutput("bp hold tag", 64'(out_tag_c), 64'h3000);
    checkOutput("bp hold imm", 64'(out_imm_c), 64'd1);
    out_ready = 1'b1;
    #1;
    checkOutput("bp in_ready release", 64'(in_ready_c), 64'd1);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkOutput("bp tag B", 64'(out_tag_c), 64'h3004);
    checkOutput("bp imm B", 64'(out_imm_c), 64'd2);
    step();
    checkOutput("bp tag C", 64'(out_tag_c), 64'h3008);
    checkOutput("bp imm C", 64'(out_imm_c), 64'd3);
    checkOutput("bp valid C", 64'(out_valid_c), 64'd1);
    step();
    checkOutput("bp drained", 64'(out_valid_c), 64'd0);

    // Reset mid-stream on the two-stage instance clears in-flight work and the counter.
    applyStimulus(1'b1, 32'h00000000, 32'h4000);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0);
    step();
    checkOutput("s2 illegal out", 64'(out_illegal_c), 64'd1);
    step();
    checkOutput("s2 cnt", 64'(cnt_c), 64'd1);
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'h00000000, 32'h4004);
    step();
    applyStimulus(1'b1, 32'h00000000, 32'h4008);
    step();
    checkOutput("s2 in flight", 64'(out_valid_c), 64'd1);
    applyStimulus(1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    #1;
    checkOutput("mid reset in_ready", 64'(in_ready_c), 64'd0);
    step();
    checkOutput("mid reset out_valid", 64'(out_valid_c), 64'd0);
    checkOutput("mid reset cnt", 64'(cnt_c), 64'd0);
    reset = 1'b0;
    step();
    checkOutput("after reset in_ready", 64'(in_ready_c), 64'd1);
    checkOutput("after reset out_valid", 64'(out_valid_c), 64'd0);
    out_ready = 1'b1;
    applyStimulus(1'b1, 32'h12345037, 32'h5000);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkOutput("new instr cycle1", 64'(out_valid_c), 64'd0);
    step();
    checkOutput("new instr cycle2", 64'(out_valid_c), 64'd1);
    checkOutput("new instr imm", 64'(out_imm_c), 64'h12345000);
    checkOutput("new instr fmt", 64'(out_fmt_c), 64'd4);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined successor to the combinational decode-stage immediate generator. It accepts 32-bit RV32I/RV64I instructions over a valid/ready handshake and classifies each one into a format. It sign-extends the immediate to XLEN and flags illegal opcodes. Each result is delivered downstream with a passthrough tag (PC) over a second valid/ready handshake. It sits between IF/ID and the ID/EX latch, and supports stall and flush.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
STAGES, 1, register stages; 1 = decode+extend in one stage, 2 = decode in stage 1, extend in stage 2.
TAG_W, 32, width of passthrough tag.
CNT_W, 16, width of the illegal-instruction counter.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous pipeline kill
in_valid  input  1  upstream instruction valid
in_ready  output  1  block can accept this cycle
in_instr  input  32  instruction word
in_tag  input  TAG_W  passthrough tag (PC)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts
out_imm  output  XLEN  sign-extended immediate
out_fmt  output  3  0=R/none, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal
out_illegal  output  1  opcode not supported
out_tag  output  TAG_W  tag of the instruction in out_*
illegal_cnt  output  CNT_W  count of illegal instructions delivered

Behaviour:
- Reset (synchronous, active-high):
  - All stage valids are cleared.
  - out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, out_tag=0, illegal_cnt=0.
  - in_ready=0 while reset is high.
- Transfers:
  - An input transfer occurs when in_valid&&in_ready.
  - An output transfer occurs when out_valid&&out_ready.
- Latency: exactly STAGES cycles from input transfer to out_valid, when there is no backpressure.
- Each stage is a full register. A stage loads when it is empty or when its content moves on in the same cycle.
  - in_ready = !flush && (stage1 empty || stage1 advancing).
  - A combinational path from out_ready to in_ready is permitted.
- Throughput: one instruction per cycle when out_ready=1.
- While out_valid=1 and out_ready=0, all out_* signals hold stable and nothing is dropped.
- Results are delivered in order.
- Format decode on opcode in_instr[6:0]:
  - I: 0010011, 0000011, 1100111, 0001111, 1110011.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111 (LUI), 0010111 (AUIPC).
  - J: 1101111.
  - R: 0110011; out_imm=0.
  - XLEN=64 only: 0011011 is I, 0111011 is R. With XLEN=32 these two opcodes are illegal.
  - Any other opcode, including any with [1:0]!=2'b11, is illegal: out_fmt=7, out_illegal=1, out_imm=0.
- Immediate construction (sign bit is always in_instr[31]; every result is sign-extended to XLEN):
  - I = instr[31:20].
  - S = {instr[31:25], instr[11:7]}.
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U = {instr[31:12], 12'b0}; for XLEN=64, bits 63:32 copy bit 31.
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- flush:
  - Clears every stage valid at the clock edge.
  - out_valid=0 on the next cycle.
  - An input offered during a flush cycle is not accepted (in_ready=0).
  - An output transfer in a flush cycle still completes.
- flush and reset both high: reset wins; the effect is identical except the counter is cleared.
- illegal_cnt:
  - Increments by 1 on each output transfer with out_illegal=1.
  - Saturates at all-ones.
  - Cleared only by reset; flush does not clear it.
  - Instructions killed by flush are not counted.
- Reset mid-stream: in-flight instructions are discarded. The cycle after reset deasserts, in_ready=1 and out_valid=0.

Test Plan:
- STAGES=1, XLEN=32: feed 0xFFF00093 (addi x1,x0,-1) with out_ready=1 -> next cycle out_valid=1, out_fmt=1, out_imm=0xFFFFFFFF.
- Stream 0xFE112E23 (sw, -4), 0x12345037 (lui), 0xFFDFF06F (jal -4), 0x00000033 (add) back-to-back -> out_imm = 0xFFFFFFFC, 0x12345000, 0xFFFFFFFC, 0x00000000; out_fmt = 2, 4, 5, 0; one result per cycle, in order.
- XLEN=64: 0x80000037 -> out_imm=0xFFFFFFFF80000000, out_fmt=4. Opcode 0011011 is accepted as fmt 1; the same opcode with XLEN=32 gives out_fmt=7.
- STAGES=2, hold out_ready=0, offer 3 instructions -> 2 are accepted, then in_ready=0. out_* stay stable. Raising out_ready delivers all 3 in order with no loss or duplication.
- Illegal 0x00000000 delivered -> out_illegal=1, out_fmt=7, illegal_cnt 0->1. A second illegal instruction flushed before delivery leaves illegal_cnt=1.
- Assert reset with 2 instructions in flight -> the next cycle out_valid=0 and illegal_cnt=0. After release, in_ready=1 and the first new instruction appears after STAGES cycles.
